// File: rtl/fp_add_sched_pkg.sv
// fp_add_sched_pkg
// Shared types and constants for the shared-adder scheduler slice.
//   FP_W    : single-precision word width
//   RM_W    : rounding-mode width
//   TAG_IDW : requester-ID width carried in the tag pipeline (covers up to
//             16 requesters; narrower configurations use the low bits)
//   fp32_t  : IEEE single-precision word {sign, exp, man}
//   tag_t   : one tag-pipeline stage {valid, requester id}
package fp_add_sched_pkg;

  localparam int FP_W    = 32;
  localparam int RM_W    = 3;
  localparam int TAG_IDW = 4;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] man;
  } fp32_t;

  typedef struct packed {
    logic               v;
    logic [TAG_IDW-1:0] id;
  } tag_t;

endpackage

// File: rtl/fp_add_rr_arb.sv
// fp_add_rr_arb
// Purely combinational round-robin arbiter. Priority starts at requester
// 'ptr' and ascends modulo N; the first requesting index wins.
//   req   in  N    request vector
//   ptr   in  IDW  highest-priority index this cycle
//   en    in  1    when low, nothing is granted
//   grant out N    one-hot grant, or zero
//   gidx  out IDW  index of the granted requester (0 when none)
module fp_add_rr_arb
  import fp_add_sched_pkg::*;
#(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  input  logic           en,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] gidx
);

  // Walk the requesters starting at ptr, wrapping at N, and take the first
  // one found. 'found' keeps later matches from overriding the winner.
  always_comb begin
    int   idx;
    logic found;
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (en && !found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        gidx       = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/fp_add_sched.sv
// fp_add_sched
// Shares one pipelined single-precision adder between NREQ requesters.
// Issues at most one operand pair per cycle (round-robin), carries the
// requester ID alongside the adder through a LAT-deep tag pipeline, and
// returns results on a single ID-tagged response channel. Response
// backpressure stalls the adder and the tag pipeline together.
//   aclk, arst_n        clock, asynchronous active-low reset
//   req_valid/req_ready per-requester handshake
//   req_a/req_b/req_rm  per-requester operands and rounding mode
//   add_a/add_b/add_rm  operands to the shared adder
//   add_stall           freezes the adder's pipeline
//   add_x               adder result
//   rsp_valid/rsp_ready response handshake
//   rsp_id/rsp_data     originating requester and result
//   busy                any operation in flight
//   stall_cnt           saturating count of stalled cycles
module fp_add_sched
  import fp_add_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int LAT  = 1,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                 aclk,
  input  logic                 arst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*FP_W-1:0] req_a,
  input  logic [NREQ*FP_W-1:0] req_b,
  input  logic [NREQ*RM_W-1:0] req_rm,
  output logic [FP_W-1:0]      add_a,
  output logic [FP_W-1:0]      add_b,
  output logic [RM_W-1:0]      add_rm,
  output logic                 add_stall,
  input  logic [FP_W-1:0]      add_x,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [FP_W-1:0]      rsp_data,
  output logic                 busy,
  output logic [15:0]          stall_cnt
);

  logic            stall;
  logic            accept;
  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  gidx;
  logic [IDW-1:0]  ptr;
  tag_t            pipe [LAT];
  fp32_t           op_a;
  fp32_t           op_b;
  logic [RM_W-1:0] op_rm;

  // A valid head that the consumer refuses freezes everything; there is
  // no skid buffer, so nothing may be accepted in that cycle either.
  assign stall     = pipe[LAT-1].v & ~rsp_ready;
  assign add_stall = stall;

  fp_add_rr_arb #(
    .N   (NREQ),
    .IDW (IDW)
  ) u_arb (
    .req   (req_valid),
    .ptr   (ptr),
    .en    (~stall),
    .grant (grant),
    .gidx  (gidx)
  );

  assign req_ready = grant & {NREQ{~stall}};
  assign accept    = |req_ready;

  // Operand mux: zeros unless a requester is granted this cycle.
  always_comb begin
    op_a  = '0;
    op_b  = '0;
    op_rm = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (req_ready[i]) begin
        op_a  = req_a[FP_W*i +: FP_W];
        op_b  = req_b[FP_W*i +: FP_W];
        op_rm = req_rm[RM_W*i +: RM_W];
      end
    end
  end

  assign add_a  = op_a;
  assign add_b  = op_b;
  assign add_rm = op_rm;

  // Pointer moves just past the requester that was accepted.
  always_ff @(posedge aclk or negedge arst_n) begin
    if (!arst_n) begin
      ptr <= '0;
    end else if (accept) begin
      if (gidx == IDW'(NREQ - 1)) ptr <= '0;
      else                        ptr <= gidx + 1'b1;
    end
  end

  // Tag pipeline runs in lock-step with the adder's enable, so the tag at
  // the last stage always describes the current add_x.
  always_ff @(posedge aclk or negedge arst_n) begin
    if (!arst_n) begin
      for (int i = 0; i < LAT; i++) pipe[i] <= '0;
    end else if (!stall) begin
      pipe[0] <= '{v: accept, id: TAG_IDW'(gidx)};
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign rsp_valid = pipe[LAT-1].v;
  assign rsp_id    = IDW'(pipe[LAT-1].id);
  assign rsp_data  = add_x;

  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < LAT; i++) busy = busy | pipe[i].v;
  end

  always_ff @(posedge aclk or negedge arst_n) begin
    if (!arst_n) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_fp_add_sched.sv
// tb_fp_add_sched
// Directed bench for fp_add_sched (NREQ=4, LAT=1) with a behavioural
// single-cycle adder, per-requester operand queues and a result scoreboard.
module tb_fp_add_sched;

  localparam int NREQ = 4;
  localparam int LAT  = 1;
  localparam int IDW  = 2;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  rm;
  } op_t;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [31:0]    data;
  } exp_t;

  logic                 aclk;
  logic                 arst_n;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*32-1:0]   req_a;
  logic [NREQ*32-1:0]   req_b;
  logic [NREQ*3-1:0]    req_rm;
  logic [31:0]          add_a;
  logic [31:0]          add_b;
  logic [2:0]           add_rm;
  logic                 add_stall;
  logic [31:0]          add_x;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [IDW-1:0]       rsp_id;
  logic [31:0]          rsp_data;
  logic                 busy;
  logic [15:0]          stall_cnt;

  op_t             opq [NREQ][$];
  exp_t            sb[$];
  int              acc_log[$];
  int              acc_cyc[$];
  int              rsp_log[$];
  int              rsp_cyc[$];
  logic [NREQ-1:0] fired;
  int              cyc;
  int              n_pass;
  int              n_fail;
  int              n_total;
  logic [31:0]     exp0;

  fp_add_sched #(
    .NREQ (NREQ),
    .LAT  (LAT),
    .IDW  (IDW)
  ) dut (
    .aclk      (aclk),
    .arst_n    (arst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_rm    (req_rm),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_rm    (add_rm),
    .add_stall (add_stall),
    .add_x     (add_x),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .busy      (busy),
    .stall_cnt (stall_cnt)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  // Reference float helpers: exact for the small integer values used here.
  function automatic real fp_to_real(input logic [31:0] x);
    real m;
    int  e;
    if (x[30:23] == 8'd0) return 0.0;
    m = 1.0 + $itor(x[22:0]) / 8388608.0;
    e = int'(x[30:23]) - 127;
    m = m * (2.0 ** e);
    return x[31] ? -m : m;
  endfunction

  function automatic logic [31:0] real_to_fp(input real r);
    logic [63:0] bits;
    int          e;
    if (r == 0.0) return 32'd0;
    bits = $realtobits(r);
    e    = int'(bits[62:52]) - 1023 + 127;
    return {bits[63], e[7:0], bits[51:29]};
  endfunction

  function automatic logic [31:0] fp_of(input int k);
    return real_to_fp($itor(k));
  endfunction

  function automatic logic [31:0] fp_add_model(input logic [31:0] a, input logic [31:0] b);
    return real_to_fp(fp_to_real(a) + fp_to_real(b));
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_total++;
    assert (observed === expected) n_pass++;
    else begin
      n_fail++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int req, input logic [31:0] a, input logic [31:0] b, input logic [2:0] rm);
    opq[req].push_back({a, b, rm});
  endtask

  task automatic clear_all();
    for (int i = 0; i < NREQ; i++) opq[i].delete();
    sb.delete();
    acc_log.delete();
    acc_cyc.delete();
    rsp_log.delete();
    rsp_cyc.delete();
    fired = '0;
  endtask

  task automatic clear_logs();
    acc_log.delete();
    acc_cyc.delete();
    rsp_log.delete();
    rsp_cyc.delete();
  endtask

  task automatic check_order(input string tag, input int got[$], input int want[$]);
    checkOutput($sformatf("%s_count", tag), 32'(got.size()), 32'(want.size()));
    for (int k = 0; k < want.size(); k++)
      if (k < got.size())
        checkOutput($sformatf("%s_%0d", tag, k), 32'(got[k]), 32'(want[k]));
  endtask

  // Behavioural adder: one result register, frozen by add_stall, no reset.
  initial begin
    add_x = '0;
    forever begin
      @(posedge aclk);
      if (!add_stall) add_x <= fp_add_model(add_a, add_b);
    end
  end

  // Requester driver: retires the head op after a handshake, presents the next.
  initial begin
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_rm    = '0;
    fired     = '0;
    cyc       = 0;
    forever begin
      @(posedge aclk);
      #1;
      cyc++;
      for (int i = 0; i < NREQ; i++) begin
        if (fired[i] && opq[i].size() > 0) opq[i].delete(0);
        fired[i] = 1'b0;
        if (opq[i].size() > 0) begin
          req_valid[i]       = 1'b1;
          req_a[32*i +: 32]  = opq[i][0].a;
          req_b[32*i +: 32]  = opq[i][0].b;
          req_rm[3*i +: 3]   = opq[i][0].rm;
        end else begin
          req_valid[i]       = 1'b0;
          req_a[32*i +: 32]  = '0;
          req_b[32*i +: 32]  = '0;
          req_rm[3*i +: 3]   = '0;
        end
      end
    end
  end

  // Mid-cycle monitor: issue checks, scoreboard push/compare, stall checks.
  initial begin
    forever begin
      @(negedge aclk);
      if (arst_n === 1'b1) begin
        if (rsp_valid === 1'b1) begin
          if (sb.size() == 0) begin
            checkOutput("rsp_unexpected", 32'd1, 32'd0);
          end else begin
            checkOutput("rsp_id", 32'(rsp_id), 32'(sb[0].id));
            checkOutput("rsp_data", rsp_data, sb[0].data);
            if (rsp_ready) begin
              sb.delete(0);
              rsp_log.push_back(int'(rsp_id));
              rsp_cyc.push_back(cyc);
            end
          end
        end
        if (rsp_valid === 1'b1 && !rsp_ready) begin
          checkOutput("stall_add_stall", 32'(add_stall), 32'd1);
          checkOutput("stall_req_ready", 32'(req_ready), 32'd0);
          checkOutput("stall_add_a", add_a, 32'd0);
        end
        checkOutput("grant_onehot", 32'($countones(req_ready) <= 1), 32'd1);
        if (req_ready == '0) checkOutput("idle_add_a", add_a, 32'd0);
        for (int i = 0; i < NREQ; i++) begin
          if (req_valid[i] && req_ready[i]) begin
            if (opq[i].size() == 0) begin
              checkOutput("issue_unexpected", 32'(i), 32'hFFFF_FFFF);
            end else begin
              fired[i] = 1'b1;
              checkOutput("issue_a", add_a, opq[i][0].a);
              checkOutput("issue_b", add_b, opq[i][0].b);
              checkOutput("issue_rm", 32'(add_rm), 32'(opq[i][0].rm));
              sb.push_back({IDW'(i), fp_add_model(opq[i][0].a, opq[i][0].b)});
              acc_log.push_back(i);
              acc_cyc.push_back(cyc);
            end
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    n_pass    = 0;
    n_fail    = 0;
    n_total   = 0;
    arst_n    = 1'b0;
    rsp_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_add_stall", 32'(add_stall), 32'd0);
    checkOutput("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    checkOutput("rst_req_ready", 32'(req_ready), 32'd0);
    @(posedge aclk);
    #2 arst_n = 1'b1;

    // Single op from requester 2: 1.0 + 2.0
    @(negedge aclk);
    applyStimulus(2, 32'h3F800000, 32'h40000000, 3'd0);
    @(negedge aclk);
    checkOutput("single_ready", 32'(req_ready), 32'h4);
    checkOutput("single_add_rm", 32'(add_rm), 32'd0);
    @(negedge aclk);
    checkOutput("single_rsp_valid", 32'(rsp_valid), 32'd1);
    checkOutput("single_rsp_id", 32'(rsp_id), 32'd2);
    checkOutput("single_rsp_data", rsp_data, 32'h40400000);
    checkOutput("single_busy", 32'(busy), 32'd1);
    repeat (3) @(negedge aclk);
    checkOutput("single_idle_busy", 32'(busy), 32'd0);

    // All four requesters valid straight out of reset
    @(posedge aclk);
    #2 arst_n = 1'b0;
    clear_all();
    for (int i = 0; i < NREQ; i++) applyStimulus(i, fp_of(i + 1), fp_of(10 * (i + 1)), 3'(i));
    @(negedge aclk);
    @(negedge aclk);
    checkOutput("inrst_req_ready", 32'(req_ready), 32'h1);
    checkOutput("inrst_rsp_valid", 32'(rsp_valid), 32'd0);
    @(posedge aclk);
    #2 arst_n = 1'b1;
    repeat (8) @(negedge aclk);
    check_order("rr_acc", acc_log, '{0, 1, 2, 3});
    check_order("rr_rsp", rsp_log, '{0, 1, 2, 3});
    for (int k = 1; k < 4; k++)
      if (k < acc_cyc.size()) checkOutput("rr_acc_gap", 32'(acc_cyc[k] - acc_cyc[k-1]), 32'd1);
    for (int k = 0; k < 4; k++)
      if (k < acc_cyc.size() && k < rsp_cyc.size())
        checkOutput("rr_rsp_lat", 32'(rsp_cyc[k] - acc_cyc[k]), 32'd1);

    // Fairness: requesters 1 and 3 continuously valid
    clear_logs();
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1, fp_of(20 + k), fp_of(3), 3'd1);
      applyStimulus(3, fp_of(40 + k), fp_of(5), 3'd3);
    end
    repeat (12) @(negedge aclk);
    check_order("fair_acc", acc_log, '{1, 3, 1, 3, 1, 3, 1, 3});
    check_order("fair_rsp", rsp_log, '{1, 3, 1, 3, 1, 3, 1, 3});

    // Backpressure: rsp_ready low for three edges with a valid head
    clear_logs();
    for (int k = 0; k < 4; k++) applyStimulus(0, fp_of(100 + k), fp_of(k + 1), 3'd2);
    exp0 = fp_add_model(fp_of(100), fp_of(1));
    @(posedge aclk);
    #1;
    @(posedge aclk);
    #1;
    checkOutput("bp_rsp_valid", 32'(rsp_valid), 32'd1);
    rsp_ready = 1'b0;
    @(negedge aclk);
    checkOutput("bp_add_stall", 32'(add_stall), 32'd1);
    checkOutput("bp_req_ready", 32'(req_ready), 32'd0);
    checkOutput("bp_rsp_id", 32'(rsp_id), 32'd0);
    checkOutput("bp_rsp_data", rsp_data, exp0);
    @(posedge aclk);
    @(posedge aclk);
    @(negedge aclk);
    checkOutput("bp_hold_id", 32'(rsp_id), 32'd0);
    checkOutput("bp_hold_data", rsp_data, exp0);
    @(posedge aclk);
    #1 rsp_ready = 1'b1;
    @(negedge aclk);
    checkOutput("bp_stall_cnt", 32'(stall_cnt), 32'd3);
    repeat (8) @(negedge aclk);
    check_order("bp_rsp", rsp_log, '{0, 0, 0, 0});
    checkOutput("bp_sb_empty", 32'(sb.size()), 32'd0);

    // Reset while a result is being presented
    clear_logs();
    applyStimulus(2, fp_of(7), fp_of(8), 3'd4);
    applyStimulus(3, fp_of(9), fp_of(6), 3'd0);
    @(posedge aclk);
    #1;
    @(posedge aclk);
    #2;
    checkOutput("mid_rsp_valid_before", 32'(rsp_valid), 32'd1);
    arst_n = 1'b0;
    clear_all();
    #1;
    checkOutput("mid_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("mid_busy", 32'(busy), 32'd0);
    checkOutput("mid_stall_cnt", 32'(stall_cnt), 32'd0);
    repeat (2) @(posedge aclk);
    #2 arst_n = 1'b1;
    applyStimulus(1, fp_of(11), fp_of(12), 3'd1);
    applyStimulus(3, fp_of(13), fp_of(14), 3'd3);
    applyStimulus(0, fp_of(15), fp_of(16), 3'd0);
    repeat (6) @(negedge aclk);
    check_order("mid_acc", acc_log, '{0, 1, 3});
    check_order("mid_rsp", rsp_log, '{0, 1, 3});

    // Stall-counter saturation
    clear_logs();
    applyStimulus(2, fp_of(50), fp_of(60), 3'd2);
    @(posedge aclk);
    #1;
    @(posedge aclk);
    #1;
    checkOutput("sat_rsp_valid", 32'(rsp_valid), 32'd1);
    rsp_ready = 1'b0;
    repeat (65534) @(posedge aclk);
    @(negedge aclk);
    checkOutput("sat_cnt_fffe", 32'(stall_cnt), 32'h0000FFFE);
    @(posedge aclk);
    @(negedge aclk);
    checkOutput("sat_cnt_ffff", 32'(stall_cnt), 32'h0000FFFF);
    repeat (5) @(posedge aclk);
    @(negedge aclk);
    checkOutput("sat_cnt_hold", 32'(stall_cnt), 32'h0000FFFF);
    checkOutput("sat_rsp_id", 32'(rsp_id), 32'd2);
    checkOutput("sat_rsp_data", rsp_data, fp_of(110));
    @(posedge aclk);
    #1 rsp_ready = 1'b1;
    repeat (4) @(negedge aclk);
    check_order("sat_rsp", rsp_log, '{2});
    checkOutput("end_sb_empty", 32'(sb.size()), 32'd0);
    checkOutput("end_busy", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
